snoop_responder: RTL and testbench
==================================

Name: snoop_responder

Overview:
- Bus-side snoop responder for the L2 MESI cache, the other end of the bus protocol the L2 initiates.
- Accepts bus operations issued by other caches and looks up the line through the L2 tag/MESI array port.
- Returns HIT/HITM/NOHIT, performs the required L1 messaging and modified-line writeback, and commits the new MESI state.

Parameters:
- ADDR_W, 32, bus address width
- INDEX_BITS, 14, set index width
- OFFSET_BITS, 6, line offset width (64 B lines)
- WAY_BITS, 4, way select width (16 ways)
- TAG_BITS = ADDR_W-INDEX_BITS-OFFSET_BITS (derived, 12)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- snp_valid  in  1  snooped bus op present
- snp_ready  out  1  responder idle, can accept
- snp_op  in  3  bus_op_t: READ=1, WRITE=2, INVALIDATE=3, RWIM=4
- snp_addr  in  ADDR_W  snooped address
- rsp_valid  out  1  one-cycle pulse, rsp_result valid
- rsp_result  out  2  snoop_result_t: HIT=0, HITM=1, NOHIT=2
- lk_req  out  1  tag lookup request
- lk_index  out  INDEX_BITS  lookup set
- lk_tag  out  TAG_BITS  lookup tag
- lk_ack  in  1  lookup done (one-cycle pulse)
- lk_hit  in  1  valid tag match (sampled with lk_ack)
- lk_way  in  WAY_BITS  matching way
- lk_mesi  in  2  mesi_t of matching way: I=0, S=1, E=2, M=3
- upd_en  out  1  one-cycle MESI write strobe
- upd_index  out  INDEX_BITS  set to update
- upd_way  out  WAY_BITS  way to update
- upd_mesi  out  2  new state
- l1_valid  out  1  L1 message valid
- l1_msg  out  3  l1_msg_t: GETLINE=1, SENDLINE=2, INVALIDATELINE=3, EVICTLINE=4
- l1_addr  out  ADDR_W  line-aligned address (offset zeroed)
- l1_ready  in  1  L1 accepts message
- wb_valid  out  1  writeback bus op valid
- wb_op  out  3  always WRITE when valid
- wb_addr  out  ADDR_W  line-aligned address
- wb_ready  in  1  bus accepts writeback
- proto_err  out  1  one-cycle pulse on illegal state/op combination
- hitm_cnt  out  32  count of HITM responses, saturating

Behaviour:
- Reset: all outputs 0, hitm_cnt=0, FSM=IDLE. Reset mid-operation abandons the transaction with no upd_en, no further messages, and no response.
- Handshakes: valid/ready. Each output valid is held with its payload stable until ready. snp_ready=1 only in IDLE.
- FSM states: IDLE, LOOKUP, RESP, L1_GET, WB, L1_INV, UPDATE.
- IDLE: on snp_valid, latch op/addr and go to LOOKUP. An illegal op (0, 5–7) is treated as WRITE.
- LOOKUP: lk_req held high until lk_ack; latch hit/way/mesi; go to RESP. Miss is treated as mesi=I.
- RESP: rsp_valid pulse for one cycle. Result: M→HITM, E/S→HIT, I→NOHIT. On HITM, increment hitm_cnt (saturates at all-ones).
- Actions by op and state:
  - READ, M: L1_GET → WB → UPDATE(S).
  - READ, E: UPDATE(S).
  - READ, S or I: return to IDLE, no update.
  - RWIM, M: L1_GET → WB → L1_INV → UPDATE(I).
  - RWIM, E/S: L1_INV → UPDATE(I).
  - RWIM, I: return to IDLE.
  - INVALIDATE, S: L1_INV → UPDATE(I).
  - INVALIDATE, E/M: proto_err pulse, no state change, return to IDLE.
  - INVALIDATE, I: return to IDLE.
  - WRITE, M: proto_err pulse, return to IDLE.
  - WRITE, otherwise: return to IDLE.
- L1_GET / L1_INV: drive l1_valid with l1_msg=GETLINE / INVALIDATELINE until l1_ready.
- WB: drive wb_valid with wb_op=WRITE until wb_ready.
- UPDATE: upd_en one cycle, then IDLE.
- Minimum latency, snp accept to rsp_valid: 2 + lookup wait (lk_ack in the cycle after lk_req rises gives rsp_valid 3 cycles after accept).
- Ready asserted in the same cycle as valid: the handshake completes that cycle and the FSM advances the next cycle.
- proto_err and rsp_valid may pulse in the same cycle.

Decomposition:
- Additions to cache_config_pkg: bus_op_t, snoop_result_t, mesi_t, l1_msg_t, INDEX_BITS, OFFSET_BITS, TAG_BITS, and a function line_align(addr).
- Address split (tag/index/offset) is combinational inside the block.
- No sub-module is required; the FSM and counter stay in one module.

Test Plan:
- READ 0x0040_0080, lookup hit mesi=E → rsp HIT; upd_en with upd_mesi=S; no l1/wb traffic.
- READ 0x1234_5678, hit M, l1_ready and wb_ready delayed 3 cycles each → rsp HITM first; GETLINE 0x1234_5640 held stable; then WRITE 0x1234_5640 held stable; upd S; hitm_cnt=1.
- RWIM on M line → HITM, GETLINE, WB WRITE, INVALIDATELINE in that order; upd_mesi=I.
- INVALIDATE on E line → rsp HIT plus proto_err pulse; no upd_en. INVALIDATE on S line → INVALIDATELINE and upd I.
- READ miss (lk_hit=0) → NOHIT; no upd_en; snp_ready returns high the cycle after rsp.
- rst_n low while wb_valid is high → all outputs 0 immediately; after reset release, snp_ready=1 and hitm_cnt=0.

Source files
------------

// File: rtl/snoop_responder_pkg.sv
// Shared types and geometry for the L2 snoop responder.
// Holds the bus/MESI/L1 message encodings, the address split widths and a
// line_align() helper that clears the line offset of an address.
package snoop_responder_pkg;

  localparam int unsigned AddrW      = 32;
  localparam int unsigned IndexBits  = 14;
  localparam int unsigned OffsetBits = 6;
  localparam int unsigned WayBits    = 4;
  localparam int unsigned TagBits    = AddrW - IndexBits - OffsetBits;

  typedef enum logic [2:0] {
    BusNone       = 3'd0,
    BusRead       = 3'd1,
    BusWrite      = 3'd2,
    BusInvalidate = 3'd3,
    BusRwim       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SnpHit   = 2'd0,
    SnpHitm  = 2'd1,
    SnpNohit = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    MesiI = 2'd0,
    MesiS = 2'd1,
    MesiE = 2'd2,
    MesiM = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    L1None           = 3'd0,
    L1Getline        = 3'd1,
    L1Sendline       = 3'd2,
    L1Invalidateline = 3'd3,
    L1Evictline      = 3'd4
  } l1_msg_t;

  function automatic logic [AddrW-1:0] line_align(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:OffsetBits], {OffsetBits{1'b0}}};
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Signal bundle of the snoop responder: snooped bus op in, snoop response out,
// tag/MESI lookup + update port, L1 message channel, writeback channel, and
// status (proto_err pulse, saturating HITM counter).
// slave  : responder side.
// master : environment side (bus, tag array, L1, writeback path).
interface snoop_responder_if;
  import snoop_responder_pkg::*;

  logic                 snp_valid;
  logic                 snp_ready;
  logic [2:0]           snp_op;
  logic [AddrW-1:0]     snp_addr;
  logic                 rsp_valid;
  logic [1:0]           rsp_result;
  logic                 lk_req;
  logic [IndexBits-1:0] lk_index;
  logic [TagBits-1:0]   lk_tag;
  logic                 lk_ack;
  logic                 lk_hit;
  logic [WayBits-1:0]   lk_way;
  logic [1:0]           lk_mesi;
  logic                 upd_en;
  logic [IndexBits-1:0] upd_index;
  logic [WayBits-1:0]   upd_way;
  logic [1:0]           upd_mesi;
  logic                 l1_valid;
  logic [2:0]           l1_msg;
  logic [AddrW-1:0]     l1_addr;
  logic                 l1_ready;
  logic                 wb_valid;
  logic [2:0]           wb_op;
  logic [AddrW-1:0]     wb_addr;
  logic                 wb_ready;
  logic                 proto_err;
  logic [31:0]          hitm_cnt;

  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_mesi, l1_ready, wb_ready,
    output snp_ready, rsp_valid, rsp_result, lk_req, lk_index, lk_tag, upd_en, upd_index,
           upd_way, upd_mesi, l1_valid, l1_msg, l1_addr, wb_valid, wb_op, wb_addr, proto_err,
           hitm_cnt
  );

  modport master (
    output snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_mesi, l1_ready, wb_ready,
    input  snp_ready, rsp_valid, rsp_result, lk_req, lk_index, lk_tag, upd_en, upd_index,
           upd_way, upd_mesi, l1_valid, l1_msg, l1_addr, wb_valid, wb_op, wb_addr, proto_err,
           hitm_cnt
  );

endinterface

// File: rtl/snoop_responder.sv
// Bus-side snoop responder for the L2 MESI cache.
// Accepts one snooped bus op at a time, looks the line up in the tag/MESI
// array, answers HIT/HITM/NOHIT, pulls/invalidates the L1 copy and writes a
// modified line back as needed, then commits the new MESI state.
// Ports: clk, rst_n (async, active low), bus (snoop_responder_if.slave).
module snoop_responder
  import snoop_responder_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  snoop_responder_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StResp,
    StL1Get,
    StWb,
    StL1Inv,
    StUpdate
  } state_e;

  state_e             state_q, state_d;
  bus_op_t            op_q, op_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [WayBits-1:0] way_q, way_d;
  mesi_t              mesi_q, mesi_d;
  logic [31:0]        hitm_cnt_q, hitm_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= BusNone;
      addr_q     <= '0;
      way_q      <= '0;
      mesi_q     <= MesiI;
      hitm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      way_q      <= way_d;
      mesi_q     <= mesi_d;
      hitm_cnt_q <= hitm_cnt_d;
    end
  end

  // Payloads come straight from the latched op so they stay stable while valid.
  assign bus.lk_index  = addr_q[OffsetBits +: IndexBits];
  assign bus.lk_tag    = addr_q[AddrW-1 -: TagBits];
  assign bus.upd_index = addr_q[OffsetBits +: IndexBits];
  assign bus.upd_way   = way_q;
  assign bus.upd_mesi  = (op_q == BusRead) ? MesiS : MesiI;
  assign bus.l1_addr   = line_align(addr_q);
  assign bus.wb_addr   = line_align(addr_q);
  assign bus.hitm_cnt  = hitm_cnt_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    way_d          = way_q;
    mesi_d         = mesi_q;
    hitm_cnt_d     = hitm_cnt_q;
    bus.snp_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_result = 2'd0;
    bus.lk_req     = 1'b0;
    bus.upd_en     = 1'b0;
    bus.l1_valid   = 1'b0;
    bus.l1_msg     = L1None;
    bus.wb_valid   = 1'b0;
    bus.wb_op      = BusNone;
    bus.proto_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.snp_ready = 1'b1;
        if (bus.snp_valid) begin
          // Undefined opcodes are handled as a plain WRITE snoop.
          op_d    = (bus.snp_op inside {[3'd1:3'd4]}) ? bus_op_t'(bus.snp_op) : BusWrite;
          addr_d  = bus.snp_addr;
          state_d = StLookup;
        end
      end

      StLookup: begin
        bus.lk_req = 1'b1;
        if (bus.lk_ack) begin
          way_d   = bus.lk_way;
          mesi_d  = bus.lk_hit ? mesi_t'(bus.lk_mesi) : MesiI;
          state_d = StResp;
        end
      end

      StResp: begin
        bus.rsp_valid = 1'b1;
        unique case (mesi_q)
          MesiM:        bus.rsp_result = SnpHitm;
          MesiE, MesiS: bus.rsp_result = SnpHit;
          default:      bus.rsp_result = SnpNohit;
        endcase
        if (mesi_q == MesiM && hitm_cnt_q != '1) hitm_cnt_d = hitm_cnt_q + 32'd1;

        state_d = StIdle;
        unique case (op_q)
          BusRead: begin
            if (mesi_q == MesiM)      state_d = StL1Get;
            else if (mesi_q == MesiE) state_d = StUpdate;
          end
          BusRwim: begin
            if (mesi_q == MesiM)      state_d = StL1Get;
            else if (mesi_q != MesiI) state_d = StL1Inv;
          end
          BusInvalidate: begin
            // Another cache cannot hold S while we hold E/M.
            if (mesi_q == MesiS)      state_d = StL1Inv;
            else if (mesi_q != MesiI) bus.proto_err = 1'b1;
          end
          BusWrite: begin
            if (mesi_q == MesiM) bus.proto_err = 1'b1;
          end
          default: ;
        endcase
      end

      StL1Get: begin
        bus.l1_valid = 1'b1;
        bus.l1_msg   = L1Getline;
        if (bus.l1_ready) state_d = StWb;
      end

      StWb: begin
        bus.wb_valid = 1'b1;
        bus.wb_op    = BusWrite;
        if (bus.wb_ready) state_d = (op_q == BusRwim) ? StL1Inv : StUpdate;
      end

      StL1Inv: begin
        bus.l1_valid = 1'b1;
        bus.l1_msg   = L1Invalidateline;
        if (bus.l1_ready) state_d = StUpdate;
      end

      StUpdate: begin
        bus.upd_en = 1'b1;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: each test pushes its hand-computed
// expected output events, a monitor pops/compares as the DUT emits them.
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if bus ();

  snoop_responder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef enum int {EvRsp, EvErr, EvL1, EvWb, EvUpd} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [63:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_cyc = 0;
  bit   chk_idle_next = 1'b0;

  int          lk_delay = 0;
  int          l1_delay = 0;
  int          wb_delay = 0;
  logic        cfg_hit = 1'b0;
  logic [3:0]  cfg_way = '0;
  logic [1:0]  cfg_mesi = '0;
  logic [13:0] exp_idx = '0;
  logic [11:0] exp_tag = '0;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  function automatic void push(input ev_kind_e k, input logic [63:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic logic [63:0] l1_ev(input logic [2:0] msg, input logic [31:0] a);
    return {29'd0, msg, a};
  endfunction

  function automatic logic [63:0] upd_ev(input logic [13:0] idx, input logic [3:0] way,
                                         input logic [1:0] mesi);
    return {44'd0, idx, way, mesi};
  endfunction

  function automatic void observe(input ev_kind_e k, input logic [63:0] d, input bit pop);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s: got data %h, expected no event", k.name(), d);
    end else begin
      if (exp_q[0].kind != k || exp_q[0].data !== d) begin
        n_fail++;
        $display("FAIL event order/data: got %s %h, expected %s %h", k.name(), d,
                 exp_q[0].kind.name(), exp_q[0].data);
      end
      if (pop) void'(exp_q.pop_front());
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    bit rsp_prev;
    rsp_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        rsp_prev = 1'b0;
      end else begin
        if (rsp_prev && chk_idle_next) check("snp_ready after rsp", 64'(bus.snp_ready), 64'd1);
        rsp_prev = 1'b0;
        if (bus.rsp_valid) begin
          observe(EvRsp, 64'(bus.rsp_result), 1'b1);
          rsp_cyc  = cyc;
          rsp_prev = 1'b1;
        end
        if (bus.proto_err) observe(EvErr, 64'd0, 1'b1);
        if (bus.l1_valid) observe(EvL1, l1_ev(bus.l1_msg, bus.l1_addr), bus.l1_ready);
        if (bus.wb_valid) observe(EvWb, l1_ev(bus.wb_op, bus.wb_addr), bus.wb_ready);
        if (bus.upd_en) observe(EvUpd, upd_ev(bus.upd_index, bus.upd_way, bus.upd_mesi), 1'b1);
      end
    end
  end

  // Tag array model.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.lk_ack = 1'b0;
        cnt = 0;
      end else if (bus.lk_req && !bus.lk_ack) begin
        if (cnt == lk_delay) begin
          check("lk_index", 64'(bus.lk_index), 64'(exp_idx));
          check("lk_tag", 64'(bus.lk_tag), 64'(exp_tag));
          bus.lk_ack  = 1'b1;
          bus.lk_hit  = cfg_hit;
          bus.lk_way  = cfg_way;
          bus.lk_mesi = cfg_mesi;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        bus.lk_ack  = 1'b0;
        bus.lk_hit  = 1'b0;
        bus.lk_mesi = 2'd0;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.l1_valid && !bus.l1_ready && cnt == l1_delay) begin
        bus.l1_ready = 1'b1;
        cnt = 0;
      end else begin
        if (rst_n && bus.l1_valid && !bus.l1_ready) cnt++;
        else cnt = 0;
        bus.l1_ready = 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid && !bus.wb_ready && cnt == wb_delay) begin
        bus.wb_ready = 1'b1;
        cnt = 0;
      end else begin
        if (rst_n && bus.wb_valid && !bus.wb_ready) cnt++;
        else cnt = 0;
        bus.wb_ready = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic hit,
                        input logic [3:0] way, input logic [1:0] mesi, input logic [13:0] idx,
                        input logic [11:0] tag, input int lkd, input int l1d, input int wbd,
                        input bit idle_next, input string name);
    int acc;
    bit done;
    lk_delay = lkd;
    l1_delay = l1d;
    wb_delay = wbd;
    cfg_hit  = hit;
    cfg_way  = way;
    cfg_mesi = mesi;
    exp_idx  = idx;
    exp_tag  = tag;
    chk_idle_next = idle_next;
    @(negedge clk);
    check({name, " snp_ready"}, 64'(bus.snp_ready), 64'd1);
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_addr  = addr;
    acc = cyc;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    bus.snp_op    = 3'd3;
    bus.snp_addr  = 32'hDEAD_BEEF;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #2;
      if (bus.snp_ready && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: %0d events pending, snp_ready=%0b, required 0 pending and idle",
               name, exp_q.size(), bus.snp_ready);
      exp_q.delete();
    end
    check({name, " latency"}, 64'(rsp_cyc - acc), 64'(2 + lkd));
  endtask

  initial begin
    bit seen;
    bus.snp_valid = 1'b0;
    bus.snp_op    = '0;
    bus.snp_addr  = '0;
    bus.lk_ack    = 1'b0;
    bus.lk_hit    = 1'b0;
    bus.lk_way    = '0;
    bus.lk_mesi   = '0;
    bus.l1_ready  = 1'b0;
    bus.wb_ready  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", 64'({bus.rsp_valid, bus.lk_req, bus.upd_en, bus.l1_valid,
                                bus.wb_valid, bus.proto_err}), 64'd0);
    check("reset hitm_cnt", 64'(bus.hitm_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // READ, E -> HIT, downgrade to S.
    push(EvRsp, 64'(SnpHit));
    push(EvUpd, upd_ev(14'h0002, 4'd3, 2'd1));
    run_op(3'd1, 32'h0040_0080, 1'b1, 4'd3, 2'd2, 14'h0002, 12'h004, 1, 0, 0, 1'b0, "read E");

    // READ, M with slow L1 and writeback.
    push(EvRsp, 64'(SnpHitm));
    push(EvL1, l1_ev(3'd1, 32'h1234_5640));
    push(EvWb, l1_ev(3'd2, 32'h1234_5640));
    push(EvUpd, upd_ev(14'h1159, 4'd5, 2'd1));
    run_op(3'd1, 32'h1234_5678, 1'b1, 4'd5, 2'd3, 14'h1159, 12'h123, 0, 3, 3, 1'b0, "read M");
    check("hitm_cnt after read M", 64'(bus.hitm_cnt), 64'd1);

    // RWIM, M.
    push(EvRsp, 64'(SnpHitm));
    push(EvL1, l1_ev(3'd1, 32'h0000_1FC0));
    push(EvWb, l1_ev(3'd2, 32'h0000_1FC0));
    push(EvL1, l1_ev(3'd3, 32'h0000_1FC0));
    push(EvUpd, upd_ev(14'h007F, 4'd15, 2'd0));
    run_op(3'd4, 32'h0000_1FC0, 1'b1, 4'd15, 2'd3, 14'h007F, 12'h000, 0, 1, 0, 1'b0, "rwim M");
    check("hitm_cnt after rwim M", 64'(bus.hitm_cnt), 64'd2);

    // INVALIDATE, E -> protocol error, no update.
    push(EvRsp, 64'(SnpHit));
    push(EvErr, 64'd0);
    run_op(3'd3, 32'hABCD_E000, 1'b1, 4'd1, 2'd2, 14'h3780, 12'hABC, 0, 0, 0, 1'b1, "inv E");

    // INVALIDATE, S.
    push(EvRsp, 64'(SnpHit));
    push(EvL1, l1_ev(3'd3, 32'hABCD_E040));
    push(EvUpd, upd_ev(14'h3781, 4'd2, 2'd0));
    run_op(3'd3, 32'hABCD_E040, 1'b1, 4'd2, 2'd1, 14'h3781, 12'hABC, 0, 2, 0, 1'b0, "inv S");

    // READ miss; lk_mesi carries junk that must be ignored.
    push(EvRsp, 64'(SnpNohit));
    run_op(3'd1, 32'h0000_0100, 1'b0, 4'd6, 2'd3, 14'h0004, 12'h000, 2, 0, 0, 1'b1, "read miss");

    // WRITE, M -> protocol error.
    push(EvRsp, 64'(SnpHitm));
    push(EvErr, 64'd0);
    run_op(3'd2, 32'h0000_0200, 1'b1, 4'd0, 2'd3, 14'h0008, 12'h000, 0, 0, 0, 1'b1, "write M");

    // Illegal opcode 6 behaves as WRITE; on S nothing else happens.
    push(EvRsp, 64'(SnpHit));
    run_op(3'd6, 32'h0000_0240, 1'b1, 4'd9, 2'd1, 14'h0009, 12'h000, 0, 0, 0, 1'b1, "op6 S");

    // RWIM, E.
    push(EvRsp, 64'(SnpHit));
    push(EvL1, l1_ev(3'd3, 32'h0000_3000));
    push(EvUpd, upd_ev(14'h00C0, 4'd7, 2'd0));
    run_op(3'd4, 32'h0000_3000, 1'b1, 4'd7, 2'd2, 14'h00C0, 12'h000, 1, 0, 0, 1'b0, "rwim E");
    check("hitm_cnt after set", 64'(bus.hitm_cnt), 64'd3);

    // Reset while the writeback is pending.
    lk_delay = 0;
    l1_delay = 0;
    wb_delay = 50;
    cfg_hit  = 1'b1;
    cfg_way  = 4'd4;
    cfg_mesi = 2'd3;
    exp_idx  = 14'h0140;
    exp_tag  = 12'h000;
    chk_idle_next = 1'b0;
    push(EvRsp, 64'(SnpHitm));
    push(EvL1, l1_ev(3'd1, 32'h0000_5000));
    push(EvWb, l1_ev(3'd2, 32'h0000_5000));
    @(negedge clk);
    bus.snp_valid = 1'b1;
    bus.snp_op    = 3'd1;
    bus.snp_addr  = 32'h0000_5000;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.wb_valid) seen = 1'b1;
    end
    check("wb_valid before reset", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-op reset outputs", 64'({bus.rsp_valid, bus.lk_req, bus.upd_en, bus.l1_valid,
                                       bus.wb_valid, bus.proto_err}), 64'd0);
    check("mid-op reset hitm_cnt", 64'(bus.hitm_cnt), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("snp_ready after reset", 64'(bus.snp_ready), 64'd1);
    check("hitm_cnt after reset", 64'(bus.hitm_cnt), 64'd0);
    repeat (3) @(negedge clk);

    // Normal operation resumes after reset.
    push(EvRsp, 64'(SnpHit));
    push(EvUpd, upd_ev(14'h0002, 4'd1, 2'd1));
    run_op(3'd1, 32'h0000_0080, 1'b1, 4'd1, 2'd2, 14'h0002, 12'h000, 0, 0, 0, 1'b0, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
